// File: rtl/clock_pkg.sv
// Shared digit type, BCD field limits and reset-time constants for the time-of-day counter.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  // Field limits as packed BCD pairs {hi, lo}
  localparam logic [7:0] SEC_MAX      = 8'h59;
  localparam logic [7:0] MIN_MAX      = 8'h59;
  localparam logic [7:0] HR24_MAX     = 8'h23;
  localparam logic [7:0] HR12_MIN     = 8'h01;
  localparam logic [7:0] HR12_MAX     = 8'h12;
  // In 12h mode the pm flag flips as the hour leaves 11 for 12
  localparam logic [7:0] HR12_PM_FLIP = 8'h11;

  // Reset time
  localparam logic [7:0] RST_SEC      = 8'h00;
  localparam logic [7:0] RST_MIN      = 8'h00;
  localparam logic [7:0] RST_HR24     = 8'h00;
  localparam logic [7:0] RST_HR12     = 8'h12;

  // Two-digit BCD increment without field wrap; callers handle wrap themselves
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    logic [3:0] hi_nxt;
    logic [3:0] lo_nxt;
    if (v[3:0] == 4'd9) begin
      hi_nxt = v[7:4] + 4'd1;
      lo_nxt = 4'd0;
    end else begin
      hi_nxt = v[7:4];
      lo_nxt = v[3:0] + 4'd1;
    end
    return {hi_nxt, lo_nxt};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter MIN_VAL..MAX_VAL with clear; carry pulses on the wrap increment.
// Latency: digits update on the edge after inc/clr; carry is combinational from inc.
// Backpressure: none; inc is always accepted, clr has priority and suppresses carry.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MIN_VAL = 8'h00,
  parameter logic [7:0] MAX_VAL = 8'h59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] lo,
  output logic [3:0] hi,
  output logic       carry
);

  logic [7:0] val_q;
  logic       at_max;

  // Wrap compares the whole two-digit value so no digit can leave 0..9
  assign at_max = (val_q == MAX_VAL);
  assign carry  = inc & ~clr & at_max;
  assign lo     = val_q[3:0];
  assign hi     = val_q[7:4];

  // Field register: clear beats increment, increment wraps at MAX_VAL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= MIN_VAL;
    end else if (clr) begin
      val_q <= MIN_VAL;
    end else if (inc) begin
      val_q <= at_max ? MIN_VAL : bcd2_inc(val_q);
    end
  end

endmodule

// File: rtl/clock_time_counter.sv
// Time-of-day counter: 1 Hz prescaler, HH:MM:SS packed BCD, hour/minute set pulses.
// Latency: digits and tick_1hz update one cycle after prescaler terminal count or set pulse.
// Backpressure: none; run=0 freezes the prescaler, set pulses always act. Macro CLOCK_12H_EN selects 12h + pm.
module clock_time_counter
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int PRE_W  = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       set_min,
  input  logic       set_hr,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic [3:0] hr_lo,
  output logic [3:0] hr_hi,
  output logic       tick_1hz,
  output logic       pm
);

  localparam logic [PRE_W-1:0] PRE_TC  = PRE_W'(CLK_HZ - 1);
  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

  logic [PRE_W-1:0] pre_q;
  logic             tc;
  logic             set_any;
  logic             tick;
  logic             sec_carry;
  logic             min_carry;
  logic             hr_inc;
  logic [7:0]       hr_q;
  logic [7:0]       hr_nxt;

  // A set pulse restarts the second, so it swallows a coincident tick and all its carries
  assign set_any = set_min | set_hr;
  assign tc      = run & (pre_q == PRE_TC);
  assign tick    = tc & ~set_any;

  // Prescaler: counts only while run, cleared by any set pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (set_any) begin
      pre_q <= '0;
    end else if (run) begin
      pre_q <= tc ? '0 : pre_q + PRE_ONE;
    end
  end

  // Second strobe registered alongside the digits it announces
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_1hz <= 1'b0;
    end else begin
      tick_1hz <= tick;
    end
  end

  bcd_mod_counter #(
    .MIN_VAL (RST_SEC),
    .MAX_VAL (SEC_MAX)
  ) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (tick),
    .clr   (set_any),
    .lo    (sec_lo),
    .hi    (sec_hi),
    .carry (sec_carry)
  );

  // sec_carry is already zero during a set, so set_min alone drives minutes then
  bcd_mod_counter #(
    .MIN_VAL (RST_MIN),
    .MAX_VAL (MIN_MAX)
  ) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (set_min | sec_carry),
    .clr   (1'b0),
    .lo    (min_lo),
    .hi    (min_hi),
    .carry (min_carry)
  );

  // Minute wrap reaches hours only on a real tick, never from set_min
  assign hr_inc = set_hr | (min_carry & tick);
  assign hr_lo  = hr_q[3:0];
  assign hr_hi  = hr_q[7:4];

`ifdef CLOCK_12H_EN
  logic pm_q;

  // 12h sequence 12,01..11,12
  always_comb begin
    hr_nxt = bcd2_inc(hr_q);
    if (hr_q == HR12_MAX) begin
      hr_nxt = HR12_MIN;
    end
  end

  // Hours register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hr_q <= RST_HR12;
    end else if (hr_inc) begin
      hr_q <= hr_nxt;
    end
  end

  // pm toggles on every 11->12 step, whether from carry or set_hr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_q <= 1'b0;
    end else if (hr_inc && (hr_q == HR12_PM_FLIP)) begin
      pm_q <= ~pm_q;
    end
  end

  assign pm = pm_q;
`else
  // 24h sequence 00..23
  always_comb begin
    hr_nxt = bcd2_inc(hr_q);
    if (hr_q == HR24_MAX) begin
      hr_nxt = RST_HR24;
    end
  end

  // Hours register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hr_q <= RST_HR24;
    end else if (hr_inc) begin
      hr_q <= hr_nxt;
    end
  end

  assign pm = 1'b0;
`endif

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed bench for clock_time_counter with CLK_HZ=4 (one second every 4 cycles).
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a. Define CLOCK_12H_EN to exercise the 12h build.
module tb_clock_time_counter;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       set_min;
  logic       set_hr;
  logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
  logic       tick_1hz;
  logic       pm;
  logic [23:0] tod;

  int checks;
  int errors;

  clock_time_counter #(
    .CLK_HZ (4),
    .PRE_W  (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .set_min  (set_min),
    .set_hr   (set_hr),
    .sec_lo   (sec_lo),
    .sec_hi   (sec_hi),
    .min_lo   (min_lo),
    .min_hi   (min_hi),
    .hr_lo    (hr_lo),
    .hr_hi    (hr_hi),
    .tick_1hz (tick_1hz),
    .pm       (pm)
  );

  assign tod = {hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_min(input int n);
    for (int i = 0; i < n; i++) begin
      set_min = 1'b1;
      step(1);
      set_min = 1'b0;
      step(1);
    end
  endtask

  task automatic pulse_hr(input int n);
    for (int i = 0; i < n; i++) begin
      set_hr = 1'b1;
      step(1);
      set_hr = 1'b0;
      step(1);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    run     = 1'b0;
    set_min = 1'b0;
    set_hr  = 1'b0;
    #3;

`ifdef CLOCK_12H_EN
    chk("rst_tod_12h", 32'(tod), 32'h120000);
    chk("rst_pm_12h", 32'(pm), 32'h0);
    chk("rst_tick_12h", 32'(tick_1hz), 32'h0);
    step(1);
    rst_n = 1'b1;
    step(1);
    pulse_hr(11);
    chk("set11_tod", 32'(tod), 32'h110000);
    chk("set11_pm", 32'(pm), 32'h0);
    pulse_hr(1);
    chk("set12_tod", 32'(tod), 32'h120000);
    chk("set12_pm", 32'(pm), 32'h1);
    pulse_hr(1);
    chk("set01_tod", 32'(tod), 32'h010000);
    chk("set01_pm", 32'(pm), 32'h1);
    run = 1'b1;
    step(3);
    chk("run12_tick_lo", 32'(tick_1hz), 32'h0);
    step(1);
    chk("run12_tick_hi", 32'(tick_1hz), 32'h1);
    chk("run12_tod", 32'(tod), 32'h010001);
    step(2);
    rst_n = 1'b0;
    #1;
    chk("arst12_tod", 32'(tod), 32'h120000);
    chk("arst12_pm", 32'(pm), 32'h0);
    chk("arst12_tick", 32'(tick_1hz), 32'h0);
`else
    // Reset state
    chk("rst_tod", 32'(tod), 32'h000000);
    chk("rst_tick", 32'(tick_1hz), 32'h0);
    chk("rst_pm", 32'(pm), 32'h0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // Tick every 4 cycles, three seconds counted
    run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk($sformatf("tick_c%0d", i), 32'(tick_1hz), (i % 4 == 3) ? 32'h1 : 32'h0);
    end
    chk("three_sec", 32'(tod), 32'h000003);

    // Preload 23:59:58 then full rollover
    run = 1'b0;
    pulse_hr(23);
    pulse_min(59);
    chk("preload_hm", 32'(tod), 32'h235900);
    run = 1'b1;
    step(58 * 4);
    chk("preload_s", 32'(tod), 32'h235958);
    step(3);
    chk("pre59_tick", 32'(tick_1hz), 32'h0);
    step(1);
    chk("t235959", 32'(tod), 32'h235959);
    chk("t235959_tick", 32'(tick_1hz), 32'h1);
    step(4);
    chk("rollover", 32'(tod), 32'h000000);
    chk("rollover_tick", 32'(tick_1hz), 32'h1);
    chk("rollover_pm", 32'(pm), 32'h0);

    // set_min at 00:59:30 wraps minutes without hour carry
    run = 1'b0;
    pulse_min(59);
    chk("min59", 32'(tod), 32'h005900);
    run = 1'b1;
    step(30 * 4);
    chk("t005930", 32'(tod), 32'h005930);
    set_min = 1'b1;
    step(1);
    set_min = 1'b0;
    chk("setmin_wrap", 32'(tod), 32'h000000);
    chk("setmin_wrap_tick", 32'(tick_1hz), 32'h0);
    run = 1'b0;
    pulse_hr(23);
    chk("hr23", 32'(tod), 32'h230000);
    pulse_hr(1);
    chk("hr_wrap", 32'(tod), 32'h000000);

    // set_min on the terminal-count cycle at 00:00:59
    run = 1'b1;
    step(59 * 4);
    chk("t000059", 32'(tod), 32'h000059);
    step(3);
    set_min = 1'b1;
    step(1);
    set_min = 1'b0;
    chk("set_vs_tick", 32'(tod), 32'h000100);
    chk("set_vs_tick_pulse", 32'(tick_1hz), 32'h0);
    step(3);
    chk("post_set_tick_lo", 32'(tick_1hz), 32'h0);
    step(1);
    chk("post_set_tick_hi", 32'(tick_1hz), 32'h1);
    chk("post_set_tod", 32'(tod), 32'h000101);

    // run=0 at prescaler count 2 holds everything
    step(2);
    run = 1'b0;
    step(10);
    chk("hold_tod", 32'(tod), 32'h000101);
    chk("hold_tick", 32'(tick_1hz), 32'h0);
    run = 1'b1;
    step(1);
    chk("resume_tick_lo", 32'(tick_1hz), 32'h0);
    step(1);
    chk("resume_tick_hi", 32'(tick_1hz), 32'h1);
    chk("resume_tod", 32'(tod), 32'h000102);

    // Async reset mid-count, then full period to the first tick
    step(1);
    rst_n = 1'b0;
    #1;
    chk("arst_tod", 32'(tod), 32'h000000);
    chk("arst_tick", 32'(tick_1hz), 32'h0);
    step(1);
    rst_n = 1'b1;
    step(3);
    chk("arst_first_lo", 32'(tick_1hz), 32'h0);
    step(1);
    chk("arst_first_hi", 32'(tick_1hz), 32'h1);
    chk("arst_first_tod", 32'(tod), 32'h000001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
